// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle restoring divider (quotient -> LO, remainder -> HI)
// Ports: clk, clr (async active-low reset), start, is_signed, dividend, divisor
//        -> busy, done (one-cycle pulse), div_zero, quotient, remainder
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a, b, r, q, t;
    logic [WIDTH:0] r_sh;
    logic sgn, q_neg, r_neg, ge;
    // Partial remainder can grow to WIDTH+1 bits after the shift; when it is
    // >= |B| the true difference fits in WIDTH bits, so a WIDTH-bit subtract suffices.
    assign r_sh = {r, q[WIDTH-1]};
    assign ge   = r_sh >= {1'b0, b};
    assign t    = r_sh[WIDTH-1:0] - b;
    always_comb begin
        state_nx = state;
        busy     = (state == PREP) || (state == ITER) || (state == FIX);
        done     = state == DONE;
        case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = ITER;
            ITER:    state_nx = (cnt == CW'(WIDTH - 1)) ? FIX : ITER;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            q         <= '0;
            sgn       <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    a   <= dividend;
                    b   <= divisor;
                    sgn <= is_signed;
                end
                PREP: begin
                    q     <= (sgn && a[WIDTH-1]) ? -a : a;
                    b     <= (sgn && b[WIDTH-1]) ? -b : b;
                    q_neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg <= sgn && a[WIDTH-1];
                    r     <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    q   <= {q[WIDTH-2:0], ge};
                    r   <= ge ? t : r_sh[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // b still holds |B| here, zero only if the divisor was zero;
                    // a still holds the raw dividend for the divide-by-zero remainder.
                    div_zero  <= b == '0;
                    quotient  <= (b == '0) ? '1 : q_neg ? -q : q;
                    remainder <= (b == '0) ? a : r_neg ? -r : r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: self-checking bench for seq_divider32 (vector table + scoreboard)
module tb_seq_divider32;
    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic clk = 0, clr = 0, start = 0, is_signed = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic busy, done, div_zero;
    logic [31:0] quotient, remainder;
    vec_t sb[$];
    vec_t tbl[12];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_zero(div_zero), .quotient(quotient), .remainder(remainder)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        int sa, sd;
        v.sgn = sgn; v.a = a; v.b = b; v.dz = 0;
        sa = $signed(a); sd = $signed(b);
        if (b == 0) begin
            v.q = '1; v.r = a; v.dz = 1;
        end else if (!sgn) begin
            v.q = a / b; v.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.q = 32'h8000_0000; v.r = 0;
        end else begin
            v.q = 32'(sa / sd); v.r = 32'(sa % sd);
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r, input logic dz);
        vec_t v;
        v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        return v;
    endfunction

    // Starts one divide, pushes its expectation, then waits (bounded) for done.
    // p1/p2: cycles at which a spurious start is pulsed; clr_at: cycle to assert reset;
    // quiet: cycles to watch after done for any second pulse.
    task automatic go(input vec_t e, input int p1, input int p2, input int clr_at, input int quiet);
        int cyc = 0, extra = 0;
        logic got = 0;
        vec_t x;
        @(negedge clk);
        is_signed = e.sgn; dividend = e.a; divisor = e.b; start = 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 0; dividend = ~e.a; divisor = e.b + 3; is_signed = ~e.sgn;
        while (cyc < 60 && !got) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) chk("busy_prep", 32'(busy), 1);
            if (cyc == clr_at) begin
                clr = 0;
                #1;
                chk("clr_busy", 32'(busy), 0);
                chk("clr_done", 32'(done), 0);
                chk("clr_dz", 32'(div_zero), 0);
                chk("clr_q", quotient, 0);
                chk("clr_r", remainder, 0);
                void'(sb.pop_back());
                @(negedge clk);
                clr = 1;
                return;
            end
            start = (cyc == p1 || cyc == p2);
            if (start) begin dividend = $urandom; divisor = $urandom; end
            if (done) begin
                got = 1;
                x = sb.pop_front();
                chk("latency", cyc, 34);
                chk("busy_done", 32'(busy), 0);
                chk("quotient", quotient, x.q);
                chk("remainder", remainder, x.r);
                chk("div_zero", 32'(div_zero), 32'(x.dz));
            end
        end
        chk("timeout", 32'(got), 1);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 0);
        if (quiet > 0) begin
            for (int i = 0; i < quiet; i++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            chk("single_done", extra, 0);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 100, 7, 14, 2, 0);
        tbl[1]  = mk(1, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
        tbl[2]  = mk(1, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 2, 0);
        tbl[3]  = mk(0, 32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 1);
        tbl[4]  = mk(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        tbl[5]  = mk(0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
        tbl[6]  = mk(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 14, 32'hFFFF_FFFE, 0);
        tbl[7]  = mk(1, 32'hFFFF_FFF0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1);
        tbl[8]  = mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
        tbl[9]  = mk(0, 5, 9, 0, 5, 0);
        tbl[10] = mk(1, 7, 2, 3, 1, 0);
        tbl[11] = mk(0, 32'h8000_0000, 3, 32'h2AAA_AAAA, 2, 0);
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dz", 32'(div_zero), 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        @(negedge clk);
        clr = 1;
        for (int i = 0; i < 12; i++) go(tbl[i], 0, 0, 0, 0);
        go(mk(0, 1000000, 37, 27027, 1, 0), 5, 20, 0, 40);
        go(mk(0, 1000000, 37, 27027, 1, 0), 0, 0, 15, 0);
        go(mk(1, 32'hFFFF_FC18, 33, 32'hFFFF_FFE2, 32'hFFFF_FFF6, 0), 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic s;
            logic [31:0] a, b;
            s = 1'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 7 == 0) b = -b;
            if (b == 0) b = 1;
            go(model(s, a, b), 0, 0, 0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
